// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO sweep controller.
//   NCO_FTW_W      default tuning-word width (matches the NCO's NCO_in)
//   NCO_DWELL_W    default dwell counter width
//   sweep_state_t  controller FSM states
//   ftw_t          tuning-word type at the default width
package nco_pkg;

    localparam int unsigned NCO_FTW_W   = 32;
    localparam int unsigned NCO_DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    typedef logic [NCO_FTW_W-1:0] ftw_t;

endpackage

// File: rtl/nco_step_clamp.sv
// One step of a clamped linear sweep, purely combinational.
//   cur      current tuning word
//   step     unsigned step magnitude
//   stop     limit word that must not be overshot
//   dir      1 = step upwards, 0 = step downwards
//   next     cur +/- step, clamped to stop (never wraps through 0 or 2^W)
//   at_stop  cur already equals stop
module nco_step_clamp
    import nco_pkg::*;
#(
    parameter int unsigned W = NCO_FTW_W
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] step,
    input  logic [W-1:0] stop,
    input  logic         dir,
    output logic [W-1:0] next,
    output logic         at_stop
);

    // One extra bit so a carry (up) or borrow (down) is seen instead of wrapping.
    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, cur} + {1'b0, step};
        diff    = {1'b0, cur} - {1'b0, step};
        at_stop = (cur == stop);
        if (dir) begin
            next = (sum >= {1'b0, stop}) ? stop : sum[W-1:0];
        end else begin
            next = (diff[W] || (diff[W-1:0] <= stop)) ? stop : diff[W-1:0];
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep (chirp) sequencer feeding an NCO.
// Emits start..stop in clamped steps, each word held cfg_dwell+1 cycles,
// single-shot or continuous, with a start/abort/done handshake.
// Optional feature macro: NCO_SWEEP_TRIANGLE_EN enables the up/down (triangle)
// mode selected by cfg_triangle; without it the sweep is sawtooth only.
// Ports:
//   clk_top, rst_top       clock, async active-low reset
//   cfg_*                  sweep configuration, captured when a start is accepted
//   start, abort           1-cycle request / immediate stop (abort wins)
//   NCO_in, NCO_enable     registered tuning word and enable to the NCO
//   busy, done, sweep_wrap status: running, end-of-single-pass, restart/reversal
module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned FTW_W   = NCO_FTW_W,
    parameter int unsigned DWELL_W = NCO_DWELL_W
) (
    input  logic               clk_top,
    input  logic               rst_top,
    input  logic [FTW_W-1:0]   cfg_start_ftw,
    input  logic [FTW_W-1:0]   cfg_stop_ftw,
    input  logic [FTW_W-1:0]   cfg_step_ftw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               cfg_triangle,
    input  logic               start,
    input  logic               abort,
    output logic [FTW_W-1:0]   NCO_in,
    output logic               NCO_enable,
    output logic               busy,
    output logic               done,
    output logic               sweep_wrap
);

    sweep_state_t       state;
    logic [FTW_W-1:0]   start_s;
    logic [FTW_W-1:0]   stop_s;
    logic [FTW_W-1:0]   step_s;
    logic [DWELL_W-1:0] dwell_s;
    logic               cont_s;
    logic               dir_up_s;
    logic [DWELL_W-1:0] cnt;

    logic [FTW_W-1:0]   tgt;
    logic               dir;
    logic [FTW_W-1:0]   fwd_next;
    logic               at_tgt;
    logic               pass_end;
    logic               rev_ok;

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic               tri_s;
    logic               returning;
    logic [FTW_W-1:0]   other;
    logic [FTW_W-1:0]   rev_next;
    logic               unused_rev_at_stop;

    // The return leg heads back to the start word in the opposite direction.
    assign tgt   = returning ? start_s : stop_s;
    assign other = returning ? stop_s : start_s;
    assign dir   = returning ? ~dir_up_s : dir_up_s;
    // Degenerate passes (single word) never reverse; single-shot stops after one return leg.
    assign rev_ok = tri_s && (start_s != stop_s) && (step_s != '0) && (!returning || cont_s);

    // First word after the endpoint, so the endpoint itself is not repeated.
    nco_step_clamp #(
        .W (FTW_W)
    ) u_rev_clamp (
        .cur     (NCO_in),
        .step    (step_s),
        .stop    (other),
        .dir     (~dir),
        .next    (rev_next),
        .at_stop (unused_rev_at_stop)
    );
`else
    logic unused_cfg_triangle;
    assign unused_cfg_triangle = cfg_triangle;
    assign tgt    = stop_s;
    assign dir    = dir_up_s;
    assign rev_ok = 1'b0;
`endif

    nco_step_clamp #(
        .W (FTW_W)
    ) u_fwd_clamp (
        .cur     (NCO_in),
        .step    (step_s),
        .stop    (tgt),
        .dir     (dir),
        .next    (fwd_next),
        .at_stop (at_tgt)
    );

    // A zero step can never reach the target, so it is a one-word pass.
    assign pass_end = at_tgt || (step_s == '0);

    always_ff @(posedge clk_top or negedge rst_top) begin
        if (!rst_top) begin
            state      <= IDLE;
            start_s    <= '0;
            stop_s     <= '0;
            step_s     <= '0;
            dwell_s    <= '0;
            cont_s     <= 1'b0;
            dir_up_s   <= 1'b0;
            cnt        <= '0;
            NCO_in     <= '0;
            NCO_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sweep_wrap <= 1'b0;
`ifdef NCO_SWEEP_TRIANGLE_EN
            tri_s      <= 1'b0;
            returning  <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            sweep_wrap <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                cnt        <= '0;
                NCO_enable <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            start_s    <= cfg_start_ftw;
                            stop_s     <= cfg_stop_ftw;
                            step_s     <= cfg_step_ftw;
                            dwell_s    <= cfg_dwell;
                            cont_s     <= cfg_continuous;
                            dir_up_s   <= (cfg_start_ftw <= cfg_stop_ftw);
                            cnt        <= '0;
                            NCO_in     <= cfg_start_ftw;
                            NCO_enable <= 1'b1;
                            busy       <= 1'b1;
                            state      <= DWELL;
`ifdef NCO_SWEEP_TRIANGLE_EN
                            tri_s      <= cfg_triangle;
                            returning  <= 1'b0;
`endif
                        end
                    end
                    DWELL: begin
                        if (cnt != dwell_s) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt <= '0;
                            if (!pass_end) begin
                                NCO_in <= fwd_next;
                            end else if (rev_ok) begin
`ifdef NCO_SWEEP_TRIANGLE_EN
                                NCO_in     <= rev_next;
                                returning  <= ~returning;
                                sweep_wrap <= cont_s;
`endif
                            end else if (cont_s) begin
                                NCO_in     <= start_s;
                                sweep_wrap <= 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
                                returning  <= 1'b0;
`endif
                            end else begin
                                state      <= DONE;
                                done       <= 1'b1;
                                busy       <= 1'b0;
                                NCO_enable <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: a word-list model of the sweep builds
// a per-cycle expectation queue that one negedge process compares against the DUT.
module tb_nco_sweep_ctrl;

    logic        clk_top = 1'b0;
    logic        rst_top = 1'b0;
    logic [31:0] cfg_start_ftw = '0;
    logic [31:0] cfg_stop_ftw = '0;
    logic [31:0] cfg_step_ftw = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_triangle = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] NCO_in;
    logic        NCO_enable;
    logic        busy;
    logic        done;
    logic        sweep_wrap;

    nco_sweep_ctrl dut (
        .clk_top        (clk_top),
        .rst_top        (rst_top),
        .cfg_start_ftw  (cfg_start_ftw),
        .cfg_stop_ftw   (cfg_stop_ftw),
        .cfg_step_ftw   (cfg_step_ftw),
        .cfg_dwell      (cfg_dwell),
        .cfg_continuous (cfg_continuous),
        .cfg_triangle   (cfg_triangle),
        .start          (start),
        .abort          (abort),
        .NCO_in         (NCO_in),
        .NCO_enable     (NCO_enable),
        .busy           (busy),
        .done           (done),
        .sweep_wrap     (sweep_wrap)
    );

    always #5 clk_top = ~clk_top;

    typedef struct packed {
        logic        chk_nco;
        logic [31:0] nco;
        logic        en;
        logic        bsy;
        logic        dn;
        logic        wrp;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cur_rec;
    logic [31:0] lst_q[$];
    logic [31:0] up_q[$];
    logic [31:0] dn_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        cnt_en = 1'b0;
    int          busy_cyc = 0;
    int          done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Word sequence of one leg: start, then clamped steps toward stop, stop exactly once.
    function automatic void make_list(input logic [31:0] s, input logic [31:0] e,
                                      input logic [31:0] st);
        longint w;
        longint ls;
        longint le;
        longint lst;
        ls  = longint'({32'b0, s});
        le  = longint'({32'b0, e});
        lst = longint'({32'b0, st});
        w   = ls;
        lst_q.delete();
        while (1) begin
            lst_q.push_back(w[31:0]);
            if (w == le || lst == 0) break;
            if (ls <= le) w = (w + lst >= le) ? le : w + lst;
            else          w = (w - lst <= le) ? le : w - lst;
        end
    endfunction

    task automatic push_word(input logic [31:0] w, input logic wrap_first, input int d);
        for (int i = 0; i <= d; i++) exp_q.push_back('{1'b1, w, 1'b1, 1'b1, 1'b0,
                                                        (i == 0) ? wrap_first : 1'b0});
    endtask

    task automatic push_done(input logic [31:0] w);
        exp_q.push_back('{1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic exp_single(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                              input int d);
        make_list(s, e, st);
        foreach (lst_q[i]) push_word(lst_q[i], 1'b0, d);
        push_done(lst_q[lst_q.size()-1]);
        push_idle(2);
    endtask

    task automatic exp_saw_cont(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                input int d, input int passes);
        make_list(s, e, st);
        for (int p = 0; p < passes; p++)
            foreach (lst_q[i]) push_word(lst_q[i], (p > 0) && (i == 0), d);
    endtask

    task automatic exp_tri(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input int d, input logic cont, input int legs);
        make_list(s, e, st);
        up_q = lst_q;
        make_list(e, s, st);
        dn_q = lst_q;
        foreach (up_q[i]) push_word(up_q[i], 1'b0, d);
        if (!cont) begin
            for (int i = 1; i < dn_q.size(); i++) push_word(dn_q[i], 1'b0, d);
            push_done(dn_q[dn_q.size()-1]);
            push_idle(2);
        end else begin
            for (int k = 0; k < legs; k++) begin
                if (k % 2 == 0)
                    for (int i = 1; i < dn_q.size(); i++) push_word(dn_q[i], i == 1, d);
                else
                    for (int i = 1; i < up_q.size(); i++) push_word(up_q[i], i == 1, d);
            end
        end
    endtask

    // Drive start at the current time (just after a rising edge), then scramble cfg.
    task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                               input int d, input logic cont, input logic tri_m);
        cfg_start_ftw  = s;
        cfg_stop_ftw   = e;
        cfg_step_ftw   = st;
        cfg_dwell      = 16'(d);
        cfg_continuous = cont;
        cfg_triangle   = tri_m;
        start          = 1'b1;
        @(posedge clk_top);
        #1;
        start          = 1'b0;
        cfg_start_ftw  = 32'h1234_5678;
        cfg_stop_ftw   = 32'h0000_0001;
        cfg_step_ftw   = 32'h0000_0007;
        cfg_dwell      = 16'd5;
        cfg_continuous = ~cont;
        cfg_triangle   = ~tri_m;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk_top);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        #1;
    endtask

    always @(negedge clk_top) begin
        if (exp_q.size() != 0) begin
            cur_rec = exp_q.pop_front();
            if (cur_rec.chk_nco) chk("NCO_in", NCO_in, cur_rec.nco);
            chk("NCO_enable", 32'(NCO_enable), 32'(cur_rec.en));
            chk("busy", 32'(busy), 32'(cur_rec.bsy));
            chk("done", 32'(done), 32'(cur_rec.dn));
            chk("sweep_wrap", 32'(sweep_wrap), 32'(cur_rec.wrp));
        end
        if (cnt_en) begin
            if (busy) busy_cyc++;
            if (done) done_cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] l2[5];
        logic [31:0] l3[4];
        logic [31:0] l4[3];
        l2 = '{32'd1000, 32'd1100, 32'd1200, 32'd1300, 32'd1400};
        l3 = '{32'd0, 32'd100, 32'd200, 32'd250};
        l4 = '{32'hFFFF_FF00, 32'hFFFF_FE80, 32'hFFFF_FE00};

        // Model pins against hand-computed word lists.
        make_list(32'd1000, 32'd1400, 32'd100);
        chk("model_t2_len", 32'(lst_q.size()), 32'd5);
        foreach (l2[i]) chk("model_t2_word", lst_q[i], l2[i]);
        make_list(32'd0, 32'd250, 32'd100);
        chk("model_t3_len", 32'(lst_q.size()), 32'd4);
        foreach (l3[i]) chk("model_t3_word", lst_q[i], l3[i]);
        make_list(32'hFFFF_FF00, 32'hFFFF_FE00, 32'h80);
        chk("model_t4a_len", 32'(lst_q.size()), 32'd3);
        foreach (l4[i]) chk("model_t4a_word", lst_q[i], l4[i]);
        make_list(32'hFFFF_FF00, 32'hFFFF_FE00, 32'hFFFF_FFFF);
        chk("model_t4b_len", 32'(lst_q.size()), 32'd2);
        chk("model_t4b_last", lst_q[1], 32'hFFFF_FE00);
        make_list(32'd250, 32'd0, 32'd100);
        chk("model_down_w1", lst_q[1], 32'd150);
        chk("model_down_w3", lst_q[3], 32'd0);

        // Reset state.
        repeat (2) @(posedge clk_top);
        #1;
        chk("rst_nco", NCO_in, 32'h0);
        chk("rst_en", 32'(NCO_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(sweep_wrap), 32'd0);
        rst_top = 1'b1;
        @(posedge clk_top);
        #1;

        // Test 1: mid-sweep asynchronous reset.
        start_sweep(32'd500, 32'd900, 32'd100, 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk_top);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst_top = 1'b0;
        #1;
        chk("arst_nco", NCO_in, 32'h0);
        chk("arst_en", 32'(NCO_enable), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_wrap", 32'(sweep_wrap), 32'd0);
        @(posedge clk_top);
        #1 rst_top = 1'b1;
        repeat (2) @(posedge clk_top);
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_en", 32'(NCO_enable), 32'd0);

        // Test 2: single up pass, plus an ignored start while busy.
        busy_cyc = 0;
        done_cyc = 0;
        cnt_en   = 1'b1;
        start_sweep(32'd1000, 32'd1400, 32'd100, 2, 1'b0, 1'b0);
        exp_single(32'd1000, 32'd1400, 32'd100, 2);
        repeat (4) @(posedge clk_top);
        #1;
        cfg_start_ftw = 32'd7;
        cfg_stop_ftw  = 32'd9;
        start         = 1'b1;
        @(posedge clk_top);
        #1 start = 1'b0;
        drain("t2");
        cnt_en = 1'b0;
        chk("t2_busy_cycles", 32'(busy_cyc), 32'd15);
        chk("t2_done_pulses", 32'(done_cyc), 32'd1);

        // Test 3: clamp on the last step.
        start_sweep(32'd0, 32'd250, 32'd100, 0, 1'b0, 1'b0);
        exp_single(32'd0, 32'd250, 32'd100, 0);
        drain("t3");

        // Test 4: downward near the top of the range, no wrap-around.
        start_sweep(32'hFFFF_FF00, 32'hFFFF_FE00, 32'h80, 0, 1'b0, 1'b0);
        exp_single(32'hFFFF_FF00, 32'hFFFF_FE00, 32'h80, 0);
        drain("t4a");
        start_sweep(32'hFFFF_FF00, 32'hFFFF_FE00, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        exp_single(32'hFFFF_FF00, 32'hFFFF_FE00, 32'hFFFF_FFFF, 1);
        drain("t4b");

        // Degenerate: zero step is a single word held dwell+1 cycles.
        start_sweep(32'd40, 32'd90, 32'd0, 3, 1'b0, 1'b0);
        exp_single(32'd40, 32'd90, 32'd0, 3);
        drain("step0");

        // Test 5: continuous sawtooth, then abort together with start.
        start_sweep(32'd0, 32'd200, 32'd100, 0, 1'b1, 1'b0);
        exp_saw_cont(32'd0, 32'd200, 32'd100, 0, 3);
        drain("t5");
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk_top);
        #1;
        abort = 1'b0;
        start = 1'b0;
        push_idle(3);
        drain("t5_abort");

        // Test 6: triangle request; sawtooth when the feature is absent.
`ifdef NCO_SWEEP_TRIANGLE_EN
        start_sweep(32'd0, 32'd200, 32'd100, 0, 1'b1, 1'b1);
        exp_tri(32'd0, 32'd200, 32'd100, 0, 1'b1, 4);
        drain("t6_tri_cont");
        abort = 1'b1;
        @(posedge clk_top);
        #1 abort = 1'b0;
        push_idle(2);
        drain("t6_abort");
        start_sweep(32'd0, 32'd250, 32'd100, 1, 1'b0, 1'b1);
        exp_tri(32'd0, 32'd250, 32'd100, 1, 1'b0, 0);
        drain("t6_tri_single");
`else
        start_sweep(32'd0, 32'd200, 32'd100, 0, 1'b1, 1'b1);
        exp_saw_cont(32'd0, 32'd200, 32'd100, 0, 3);
        drain("t6_saw");
        abort = 1'b1;
        @(posedge clk_top);
        #1 abort = 1'b0;
        push_idle(2);
        drain("t6_abort");
        start_sweep(32'd0, 32'd250, 32'd100, 1, 1'b0, 1'b1);
        exp_single(32'd0, 32'd250, 32'd100, 1);
        drain("t6_single");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
